// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between the requesters and the 16-way round-robin arbiter.
// master: the requester side driving en/req/release_grant; slave: the arbiter.
interface rr_arbiter_16_if;
  logic        en;
  logic [15:0] req;
  // Current owner ends its grant; only looked at while a grant is active.
  logic        release_grant;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        prime_grant;
  logic        timeout;

  modport master (
    output en, req, release_grant,
    input  grant, grant_idx, grant_valid, prime_grant, timeout
  );

  modport slave (
    input  en, req, release_grant,
    output grant, grant_idx, grant_valid, prime_grant, timeout
  );
endinterface

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter sharing one resource among 16 requesters.
// A two-state FSM (IDLE/BUSY) holds the owner index in a register; the one-hot
// grant and the prime-slot flag are registered alongside it so they never glitch.
// A grant ends on release, on the owner dropping its request, on en low, or after
// MAX_HOLD cycles; only the last cause alone raises the one-cycle timeout pulse.
module rr_arbiter_16 #(
  parameter int MAX_HOLD = 8
) (
  input logic             clk,
  input logic             rst,
  rr_arbiter_16_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state;
  logic [3:0]  ptr;
  logic [7:0]  hold_cnt;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        prime_grant;
  logic        timeout;

  logic [3:0]  next_idx;
  logic        hold_expired;
  logic        early_end;

  // First set request scanning ptr, ptr+1, .. wrapping mod 16. Scanning from the
  // far end down lets the closest candidate overwrite the others.
  function automatic logic [3:0] pick(input logic [15:0] r, input logic [3:0] p);
    logic [3:0] k;
    logic [3:0] sel;
    sel = p;
    for (int i = 15; i >= 0; i--) begin
      k = p + 4'(i);
      if (r[k]) sel = k;
    end
    return sel;
  endfunction

  function automatic logic [15:0] decode(input logic [3:0] i);
    return 16'h0001 << i;
  endfunction

  // Slots 2,3,5,7,11,13 get special downstream handling.
  function automatic logic is_prime(input logic [3:0] i);
    logic p;
    case (i)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: p = 1'b1;
      default:                               p = 1'b0;
    endcase
    return p;
  endfunction

  // Arbitration candidate and the end-of-grant causes for the current owner.
  always_comb begin
    next_idx     = pick(bus.req, ptr);
    hold_expired = (hold_cnt == HOLD_LAST);
    early_end    = bus.release_grant | ~bus.req[grant_idx] | ~bus.en;
  end

  // Grant FSM with registered outputs; reset overrides any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 4'd0;
      hold_cnt    <= 8'd0;
      grant       <= 16'h0000;
      grant_idx   <= 4'd0;
      grant_valid <= 1'b0;
      prime_grant <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en && (|bus.req)) begin
            grant_idx   <= next_idx;
            grant       <= decode(next_idx);
            prime_grant <= is_prime(next_idx);
            grant_valid <= 1'b1;
            hold_cnt    <= 8'd0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (early_end || hold_expired) begin
            // grant_idx keeps the last owner; the pointer moves just past it.
            grant       <= 16'h0000;
            prime_grant <= 1'b0;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 4'd1;
            timeout     <= hold_expired & ~early_end;
            state       <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_idx   = grant_idx;
  assign bus.grant_valid = grant_valid;
  assign bus.prime_grant = prime_grant;
  assign bus.timeout     = timeout;

endmodule
